wshb_arbiter: RTL and testbench

- Two-master, one-slave Wishbone arbiter in front of the SDRAM framebuffer controller.
- Master 0 is the pattern/pixel writer; master 1 is the display read path.
- Grants the slave bus round-robin, holds a grant for the whole cyc of the owner, and pre-empts the owner after MAX_GRANT acknowledged transfers when the other master is waiting. This stops one master from starving the other.

---
 rtl/wshb_arbiter.sv | 173 +++++++++++++++++
 tb/tb_wshb_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wshb_arbiter.sv
// wshb_arbiter
// Two-master, one-slave Wishbone arbiter in front of the SDRAM framebuffer
// controller. Master 0 is the pattern/pixel writer and master 1 is the
// display read path. The bus is granted round-robin and held for the whole
// cyc of the owner. After MAX_GRANT acknowledged transfers the owner is
// pre-empted if the other master is waiting, so neither master can starve
// the other.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   m0_* / m1_*       master-side Wishbone (cyc, stb, we, adr, dat_ms, sel,
//                     cti, bte in; ack, dat_sm out)
//   s_*               slave-side Wishbone (cyc, stb, we, adr, dat_ms, sel,
//                     cti, bte out; ack, dat_sm in)
//   gnt               one-hot current owner, 00 when idle
module wshb_arbiter #(
  parameter int ADR_W     = 32,
  parameter int DAT_W     = 16,
  parameter int MAX_GRANT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_cyc,
  input  logic               m0_stb,
  input  logic               m0_we,
  input  logic [ADR_W-1:0]   m0_adr,
  input  logic [DAT_W-1:0]   m0_dat_ms,
  input  logic [DAT_W/8-1:0] m0_sel,
  input  logic [2:0]         m0_cti,
  input  logic [1:0]         m0_bte,
  output logic               m0_ack,
  output logic [DAT_W-1:0]   m0_dat_sm,
  input  logic               m1_cyc,
  input  logic               m1_stb,
  input  logic               m1_we,
  input  logic [ADR_W-1:0]   m1_adr,
  input  logic [DAT_W-1:0]   m1_dat_ms,
  input  logic [DAT_W/8-1:0] m1_sel,
  input  logic [2:0]         m1_cti,
  input  logic [1:0]         m1_bte,
  output logic               m1_ack,
  output logic [DAT_W-1:0]   m1_dat_sm,
  output logic               s_cyc,
  output logic               s_stb,
  output logic               s_we,
  output logic [ADR_W-1:0]   s_adr,
  output logic [DAT_W-1:0]   s_dat_ms,
  output logic [DAT_W/8-1:0] s_sel,
  output logic [2:0]         s_cti,
  output logic [1:0]         s_bte,
  input  logic               s_ack,
  input  logic [DAT_W-1:0]   s_dat_sm,
  output logic [1:0]         gnt
);

  localparam int CNT_W = $clog2(MAX_GRANT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_GRANT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_GRANT - 1);

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             prio;
  logic [CNT_W-1:0] cnt;
  logic             quota_done;

  // True on the cycle whose s_ack completes (or is past) the grant quota;
  // a pre-emption therefore only ever lands on the edge after an ack.
  assign quota_done = s_ack && (cnt >= CNT_LAST);

  // Next-state: round-robin from idle, direct hand-over when the owner
  // drops cyc, and pre-emption once the quota is used up.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_cyc && (!prio || !m1_cyc))
          state_nxt = GNT0;
        else if (m1_cyc)
          state_nxt = GNT1;
      end
      GNT0: begin
        if (!m0_cyc)
          state_nxt = m1_cyc ? GNT1 : IDLE;
        else if (m1_cyc && quota_done)
          state_nxt = GNT1;
      end
      GNT1: begin
        if (!m1_cyc)
          state_nxt = m0_cyc ? GNT0 : IDLE;
        else if (m0_cyc && quota_done)
          state_nxt = GNT0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, priority pointer and saturating per-grant ack counter. The
  // pointer always names the master that did not just receive the bus;
  // dropping to idle leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prio  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
        if (state_nxt == GNT0)
          prio <= 1'b1;
        else if (state_nxt == GNT1)
          prio <= 1'b0;
      end else if (state == IDLE) begin
        cnt <= '0;
      end else if (s_ack && (cnt != CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Zero-latency routing from the registered owner; everything idles low.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    s_cti    = '0;
    s_bte    = '0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    gnt      = 2'b00;
    case (state)
      GNT0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
        s_cti    = m0_cti;
        s_bte    = m0_bte;
        m0_ack   = s_ack;
        gnt      = 2'b01;
      end
      GNT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        s_cti    = m1_cti;
        s_bte    = m1_bte;
        m1_ack   = s_ack;
        gnt      = 2'b10;
      end
      default: ;
    endcase
  end

  // Read data goes to both masters; only the owner's ack qualifies it.
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

endmodule

// File: tb/tb_wshb_arbiter.sv
// tb_wshb_arbiter
// Self-checking bench for wshb_arbiter. A behavioural model tracks the
// owner, the round-robin turn and the acks taken in the current grant;
// every cycle the DUT outputs are compared with what that model implies.
// Directed scenarios are followed by a randomized run.
module tb_wshb_arbiter;

  localparam int MAXG = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        mc[2];
  logic        mstb[2];
  logic        mw[2];
  logic [31:0] ma[2];
  logic [15:0] md[2];
  logic [1:0]  ms[2];
  logic [2:0]  mcti[2];
  logic [1:0]  mbte[2];
  logic        s_ack;
  logic [15:0] s_dat_sm;

  logic        m0_ack, m1_ack;
  logic [15:0] m0_dat_sm, m1_dat_sm;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr;
  logic [15:0] s_dat_ms;
  logic [1:0]  s_sel;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic [1:0]  gnt;

  // model: owner -1 = idle, turn = master that wins a tie, acks this grant
  int owner = -1;
  int turn  = 0;
  int acks  = 0;

  int          errors = 0;
  int          checks = 0;
  int          obs_ack0, obs_ack1;
  logic [1:0]  obs_gnt;
  logic        exp_ack[2];

  always #5 clk = ~clk;

  wshb_arbiter #(.ADR_W(32), .DAT_W(16), .MAX_GRANT(MAXG)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(mc[0]), .m0_stb(mstb[0]), .m0_we(mw[0]), .m0_adr(ma[0]),
    .m0_dat_ms(md[0]), .m0_sel(ms[0]), .m0_cti(mcti[0]), .m0_bte(mbte[0]),
    .m0_ack(m0_ack), .m0_dat_sm(m0_dat_sm),
    .m1_cyc(mc[1]), .m1_stb(mstb[1]), .m1_we(mw[1]), .m1_adr(ma[1]),
    .m1_dat_ms(md[1]), .m1_sel(ms[1]), .m1_cti(mcti[1]), .m1_bte(mbte[1]),
    .m1_ack(m1_ack), .m1_dat_sm(m1_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_ack(s_ack), .s_dat_sm(s_dat_sm), .gnt(gnt)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [57:0] bus_of(input int m);
    return {mc[m], mstb[m], mw[m], ma[m], md[m], ms[m], mcti[m], mbte[m]};
  endfunction

  task automatic new_xfer(input int m);
    mw[m]   = 1'($urandom);
    ma[m]   = $urandom;
    md[m]   = 16'($urandom);
    ms[m]   = 2'($urandom);
    mcti[m] = 3'($urandom);
    mbte[m] = 2'($urandom);
  endtask

  task automatic set_master(input int m, input logic on);
    mc[m]   = on;
    mstb[m] = on;
    if (on) new_xfer(m);
  endtask

  // Next owner and counters from the arbitration rules.
  task automatic model_step();
    int nxt;
    int other;
    if (rst) begin
      owner = -1;
      turn  = 0;
      acks  = 0;
    end else begin
      nxt = owner;
      if (owner < 0) begin
        if (mc[0] && mc[1]) nxt = turn;
        else if (mc[0])     nxt = 0;
        else if (mc[1])     nxt = 1;
      end else begin
        other = 1 - owner;
        if (!mc[owner])
          nxt = mc[other] ? other : -1;
        else if (s_ack && mc[other] && (acks + 1 >= MAXG))
          nxt = other;
      end
      if (nxt != owner) begin
        acks = 0;
        if (nxt >= 0) turn = 1 - nxt;
      end else if (owner >= 0 && s_ack && acks < MAXG) begin
        acks++;
      end
      owner = nxt;
    end
  endtask

  // One clock: check outputs mid-cycle, advance the model on the edge.
  task automatic stepCycle();
    logic [1:0]  eg;
    logic [57:0] ebus;
    s_dat_sm = 16'($urandom);
    @(negedge clk);
    eg   = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    ebus = (owner >= 0) ? bus_of(owner) : '0;
    exp_ack[0] = (owner == 0) && s_ack;
    exp_ack[1] = (owner == 1) && s_ack;
    checkOutput("gnt", 64'(gnt), 64'(eg));
    checkOutput("s_bus", 64'({s_cyc, s_stb, s_we, s_adr, s_dat_ms, s_sel, s_cti, s_bte}),
                64'(ebus));
    checkOutput("m0_ack", 64'(m0_ack), 64'(exp_ack[0]));
    checkOutput("m1_ack", 64'(m1_ack), 64'(exp_ack[1]));
    checkOutput("m0_dat_sm", 64'(m0_dat_sm), 64'(s_dat_sm));
    checkOutput("m1_dat_sm", 64'(m1_dat_sm), 64'(s_dat_sm));
    obs_gnt = gnt;
    if (m0_ack === 1'b1) obs_ack0++;
    if (m1_ack === 1'b1) obs_ack1++;
    @(posedge clk);
    model_step();
    #1;
    for (int m = 0; m < 2; m++)
      if (exp_ack[m] && mc[m]) new_xfer(m);
  endtask

  // Random master/slave behaviour for the soak phase.
  task automatic applyStimulus();
    rst = ($urandom_range(299) == 0);
    for (int m = 0; m < 2; m++) begin
      if (mc[m]) begin
        if (exp_ack[m]) begin
          if ($urandom_range(7) == 0) set_master(m, 1'b0);
          else mstb[m] = ($urandom_range(5) != 0);
        end else if ($urandom_range(39) == 0) begin
          set_master(m, 1'b0);
        end else if (!mstb[m]) begin
          mstb[m] = 1'($urandom);
        end
      end else if ($urandom_range(4) == 0) begin
        set_master(m, 1'b1);
        mstb[m] = ($urandom_range(3) != 0);
      end
    end
    s_ack = (owner >= 0) && mstb[owner] && ($urandom_range(3) != 0);
  endtask

  task automatic idle_all();
    set_master(0, 1'b0);
    set_master(1, 1'b0);
    s_ack = 1'b0;
    stepCycle();
    stepCycle();
  endtask

  initial begin
    int n;
    int bad;
    int w;
    rst = 1'b1;
    s_ack = 1'b0;
    s_dat_sm = '0;
    exp_ack[0] = 1'b0;
    exp_ack[1] = 1'b0;
    for (int m = 0; m < 2; m++) begin
      set_master(m, 1'b0);
      new_xfer(m);
    end
    @(posedge clk);
    #1;
    stepCycle();
    rst = 1'b0;
    stepCycle();

    // Four simultaneous contests; loser withdraws, so the winner alternates.
    for (int k = 0; k < 4; k++) begin
      set_master(0, 1'b1);
      set_master(1, 1'b1);
      s_ack = 1'b0;
      stepCycle();
      w = k % 2;
      set_master(1 - w, 1'b0);
      s_ack = 1'b1;
      stepCycle();
      checkOutput("contest_winner", 64'(obs_gnt), (w == 1) ? 64'h2 : 64'h1);
      stepCycle();
      idle_all();
    end

    // Direct hand-over with no idle cycle when the owner drops cyc.
    set_master(0, 1'b1);
    set_master(1, 1'b1);
    s_ack = 1'b0;
    stepCycle();
    s_ack = 1'b1;
    stepCycle();
    stepCycle();
    set_master(0, 1'b0);
    s_ack = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("direct_handover", 64'(obs_gnt), 64'h2);
    idle_all();

    // m0 alone, ten writes with an ack every cycle.
    obs_ack0 = 0;
    obs_ack1 = 0;
    set_master(0, 1'b1);
    mw[0] = 1'b1;
    s_ack = 1'b1;
    repeat (11) stepCycle();
    set_master(0, 1'b0);
    s_ack = 1'b0;
    stepCycle();
    checkOutput("ten_writes_acks", 64'(obs_ack0), 64'd10);
    checkOutput("ten_writes_m1", 64'(obs_ack1), 64'd0);
    idle_all();

    // Pre-emption after MAXG acks with m1 waiting.
    set_master(0, 1'b1);
    s_ack = 1'b0;
    stepCycle();
    obs_ack0 = 0;
    set_master(1, 1'b1);
    s_ack = 1'b1;
    n = 0;
    obs_gnt = 2'b01;
    while (obs_gnt != 2'b10 && n < 200) begin
      stepCycle();
      n++;
    end
    checkOutput("preempt_gnt", 64'(obs_gnt), 64'h2);
    checkOutput("preempt_acks", 64'(obs_ack0), 64'(MAXG));
    stepCycle();
    idle_all();

    // m0 alone for 200 acks keeps the bus; saturated count hands over on next ack.
    set_master(0, 1'b1);
    s_ack = 1'b0;
    stepCycle();
    s_ack = 1'b1;
    bad = 0;
    repeat (200) begin
      stepCycle();
      if (obs_gnt != 2'b01) bad++;
    end
    checkOutput("saturate_hold", 64'(bad), 64'd0);
    set_master(1, 1'b1);
    s_ack = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("saturate_wait", 64'(obs_gnt), 64'h1);
    s_ack = 1'b1;
    stepCycle();
    s_ack = 1'b0;
    stepCycle();
    checkOutput("saturate_handover", 64'(obs_gnt), 64'h2);
    idle_all();

    // Delayed ack on the 64th transfer while m1 waits.
    set_master(0, 1'b1);
    s_ack = 1'b0;
    stepCycle();
    obs_ack0 = 0;
    s_ack = 1'b1;
    repeat (MAXG - 1) stepCycle();
    s_ack = 1'b0;
    set_master(1, 1'b1);
    repeat (3) stepCycle();
    checkOutput("delay_hold", 64'(obs_gnt), 64'h1);
    s_ack = 1'b1;
    stepCycle();
    s_ack = 1'b0;
    stepCycle();
    checkOutput("delay_switch", 64'(obs_gnt), 64'h2);
    checkOutput("delay_acks", 64'(obs_ack0), 64'(MAXG));

    // Reset while m1 owns the bus mid-transfer; both keep requesting.
    s_ack = 1'b1;
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    s_ack = 1'b0;
    stepCycle();
    checkOutput("reset_idle", 64'(obs_gnt), 64'h0);
    stepCycle();
    checkOutput("reset_prio_m0", 64'(obs_gnt), 64'h1);
    idle_all();

    // Randomized soak against the model.
    repeat (4000) begin
      applyStimulus();
      stepCycle();
    end
    rst = 1'b0;
    idle_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
